frame_store: RTL and testbench
==============================

Name: frame_store

Overview:
- Double-buffered frame memory sitting directly downstream of the SPI receive stage.
- Accepts (data, address, write_strobe) word writes, already in the system clock domain, into a back bank.
- Marks the back bank complete when the last word of a frame lands, then swaps banks at the display scanner's next vsync.
- The display scanner reads the front bank through a 1-cycle-latency read port.

Parameters:
- ADDR_WIDTH, 11, width of word address; bank depth is 2^ADDR_WIDTH.
- DATA_WIDTH, 16, width of a data word.
- FRAME_WORDS, 2048, words per frame; last word address is FRAME_WORDS-1; must be <= 2^ADDR_WIDTH.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- wr_data  in  DATA_WIDTH  frame word from receive stage.
- wr_address  in  ADDR_WIDTH  word address from receive stage.
- write_strobe  in  1  single-cycle pulse; wr_data/wr_address valid this cycle.
- scan_vsync  in  1  single-cycle pulse from scanner at start of display frame.
- rd_address  in  ADDR_WIDTH  scanner read address into front bank.
- rd_data  out  DATA_WIDTH  front-bank word, registered.
- front_bank  out  1  bank currently displayed.
- frame_pending  out  1  back bank complete, awaiting swap.
- swap_strobe  out  1  single-cycle pulse on the cycle after a swap occurs.
- seq_error  out  1  sticky; out-of-sequence address seen.
- overrun_count  out  8  saturating count of writes dropped while pending.
- err_clear  in  1  clears seq_error and overrun_count.

Behaviour:
- Reset (async assert): front_bank=0, state=IDLE, frame_pending=0, swap_strobe=0, seq_error=0, overrun_count=0, rd_data=0, expected address=0. Memory contents are not reset.
- Storage: two banks of 2^ADDR_WIDTH x DATA_WIDTH, inferred as block RAM. Writes go to bank ~front_bank; reads come from bank front_bank.
- Read port: rd_data is registered to mem[front_bank][rd_address] one clock after rd_address is presented. After a swap, the first read reflects the new front_bank.
- State machine: IDLE, FILLING, PENDING.
- IDLE, write_strobe, address 0: write the word, expected=1, go to FILLING.
- IDLE, write_strobe, address !=0: drop the write, set seq_error.
- FILLING, write_strobe, address == expected: write the word, expected+1.
  - If address == FRAME_WORDS-1, go to PENDING and assert frame_pending.
- FILLING, write_strobe, address == 0: write the word, set seq_error, restart with expected=1 and stay in FILLING. This is a resync: the partial frame is discarded.
- FILLING, write_strobe, any other address: drop the write, set seq_error, go to IDLE.
- PENDING: the back bank is frozen. Every write_strobe is dropped and overrun_count increments, saturating at 255.
- PENDING, scan_vsync: toggle front_bank, clear frame_pending, go to IDLE. swap_strobe pulses on the next cycle.
- scan_vsync outside PENDING: no effect.
- Simultaneous events:
  - Final-word write and scan_vsync in the same cycle: the write is taken and PENDING is entered; the swap waits for the next vsync.
  - err_clear together with a new error: the new error wins (set has priority over clear).
- FRAME_WORDS=1 degenerate case: a write to address 0 in IDLE goes straight to PENDING.
- Latency:
  - Write to memory: same edge as write_strobe.
  - frame_pending: visible the cycle after the final word.
  - Swap: visible the cycle after vsync.

Test Plan:
- Reset, then 2048 sequential writes (data=address^16'hA5A5), then scan_vsync -> frame_pending rises after the word at 2047; swap_strobe pulses once; front_bank=1; reading address 5 returns 16'hA5A0 one cycle later.
- Writes 0..9, then address 20 -> seq_error=1, state IDLE, no frame_pending. Then err_clear -> seq_error=0.
- Writes 0..99, then address 0 again, then 1..2047 -> seq_error=1; frame completes; after vsync the front bank holds the second-pass data.
- Complete a frame, then 300 writes before vsync -> overrun_count=255 (saturated); front bank unchanged; after vsync the old back bank is displayed.
- Write to 2047 and scan_vsync in the same cycle -> no swap (front_bank unchanged, swap_strobe=0); the next vsync swaps.
- Assert reset asynchronously mid-frame (after address 1000) -> all outputs return to reset values immediately; the next frame from address 0 fills bank 1 normally.

Source files
------------

// File: rtl/frame_store.sv
// frame_store
// Double-buffered frame memory fed by the SPI receive stage. Incoming words
// are written in strict address order into the back bank; once the final
// word of a frame lands the back bank is frozen until the display scanner's
// next vsync, at which point the banks swap and the scanner reads the new
// frame through a registered read port.
//
// Ports:
//   clock          system clock
//   reset          asynchronous, active-high reset
//   wr_data        frame word from the receive stage
//   wr_address     word address from the receive stage
//   write_strobe   single-cycle pulse, wr_data/wr_address valid
//   scan_vsync     single-cycle pulse at start of a display frame
//   rd_address     scanner read address into the front bank
//   rd_data        front-bank word, one clock after rd_address
//   front_bank     bank currently being displayed
//   frame_pending  back bank complete, waiting for vsync
//   swap_strobe    one-cycle pulse on the cycle after a swap
//   seq_error      sticky flag, out-of-sequence address seen
//   overrun_count  saturating count of writes dropped while pending
//   err_clear      clears seq_error and overrun_count
module frame_store #(
  parameter int ADDR_WIDTH  = 11,
  parameter int DATA_WIDTH  = 16,
  parameter int FRAME_WORDS = 2048
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] wr_address,
  input  logic                  write_strobe,
  input  logic                  scan_vsync,
  input  logic [ADDR_WIDTH-1:0] rd_address,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  front_bank,
  output logic                  frame_pending,
  output logic                  swap_strobe,
  output logic                  seq_error,
  output logic [7:0]            overrun_count,
  input  logic                  err_clear
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    FILLING,
    PENDING
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] expected;
  logic                  write_en;

  // Both banks live in one array; the bank select is the top address bit.
  // No reset so the array maps onto block RAM.
  logic [DATA_WIDTH-1:0] mem [0:2*DEPTH-1];

  // A word is stored when it starts a frame (address 0 from IDLE, or a
  // resync to address 0 mid-frame) or continues the frame in order.
  // Anything arriving while PENDING is dropped so the back bank stays frozen.
  always_comb begin
    write_en = 1'b0;
    if (write_strobe) begin
      case (state)
        IDLE:    write_en = (wr_address == '0);
        FILLING: write_en = (wr_address == expected) || (wr_address == '0);
        default: write_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (write_en) begin
      mem[{~front_bank, wr_address}] <= wr_data;
    end
  end

  // Read uses the registered front_bank, so the first read issued after a
  // swap edge already comes from the newly displayed bank.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[{front_bank, rd_address}];
    end
  end

  // Sequencing FSM. Error sets are written after the clear so that a new
  // error in the same cycle as err_clear survives.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      expected      <= '0;
      front_bank    <= 1'b0;
      frame_pending <= 1'b0;
      swap_strobe   <= 1'b0;
      seq_error     <= 1'b0;
      overrun_count <= '0;
    end else begin
      swap_strobe <= 1'b0;
      if (err_clear) begin
        seq_error     <= 1'b0;
        overrun_count <= '0;
      end
      case (state)
        IDLE: begin
          if (write_strobe) begin
            if (wr_address == '0) begin
              expected <= ONE_ADDR;
              if (LAST_ADDR == '0) begin
                state         <= PENDING;
                frame_pending <= 1'b1;
              end else begin
                state <= FILLING;
              end
            end else begin
              seq_error <= 1'b1;
            end
          end
        end
        FILLING: begin
          if (write_strobe) begin
            if (wr_address == expected) begin
              expected <= expected + ONE_ADDR;
              if (wr_address == LAST_ADDR) begin
                state         <= PENDING;
                frame_pending <= 1'b1;
              end
            end else if (wr_address == '0) begin
              // Resync: the word at 0 restarts the frame over the partial one.
              seq_error <= 1'b1;
              expected  <= ONE_ADDR;
            end else begin
              seq_error <= 1'b1;
              expected  <= '0;
              state     <= IDLE;
            end
          end
        end
        PENDING: begin
          if (write_strobe) begin
            if (err_clear) begin
              overrun_count <= 8'd1;
            end else if (overrun_count != 8'hFF) begin
              overrun_count <= overrun_count + 8'd1;
            end
          end
          if (scan_vsync) begin
            front_bank    <= ~front_bank;
            frame_pending <= 1'b0;
            swap_strobe   <= 1'b1;
            expected      <= '0;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_store.sv
// tb_frame_store
// Self-checking bench for frame_store. Inputs are driven on the falling edge
// and outputs sampled on the following falling edge. Read-port expectations
// go through a queue and are popped when rd_data is due.
module tb_frame_store;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] wr_data;
  logic [10:0] wr_address;
  logic        write_strobe;
  logic        scan_vsync;
  logic [10:0] rd_address;
  logic [15:0] rd_data;
  logic        front_bank;
  logic        frame_pending;
  logic        swap_strobe;
  logic        seq_error;
  logic [7:0]  overrun_count;
  logic        err_clear;

  int n_vec  = 0;
  int n_fail = 0;

  logic [15:0] exp_q[$];

  typedef struct {
    logic [10:0] addr;
    logic [15:0] exp;
  } rd_vec_t;

  rd_vec_t t1_vec[7];

  frame_store #(
    .ADDR_WIDTH (11),
    .DATA_WIDTH (16),
    .FRAME_WORDS(2048)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .wr_data      (wr_data),
    .wr_address   (wr_address),
    .write_strobe (write_strobe),
    .scan_vsync   (scan_vsync),
    .rd_address   (rd_address),
    .rd_data      (rd_data),
    .front_bank   (front_bank),
    .frame_pending(frame_pending),
    .swap_strobe  (swap_strobe),
    .seq_error    (seq_error),
    .overrun_count(overrun_count),
    .err_clear    (err_clear)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One cycle of write stimulus, optionally with vsync in the same cycle.
  task automatic apply_stimulus(input logic [10:0] a, input logic [15:0] d,
                                input logic vs, input logic clr);
    wr_address   = a;
    wr_data      = d;
    write_strobe = 1'b1;
    scan_vsync   = vs;
    err_clear    = clr;
    @(negedge clock);
    write_strobe = 1'b0;
    scan_vsync   = 1'b0;
    err_clear    = 1'b0;
  endtask

  task automatic write_frame(input int first, input int last, input logic [15:0] pat);
    for (int a = first; a <= last; a++) begin
      apply_stimulus(11'(a), 16'(a) ^ pat, 1'b0, 1'b0);
    end
  endtask

  task automatic pulse_vsync();
    scan_vsync = 1'b1;
    @(negedge clock);
    scan_vsync = 1'b0;
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    @(negedge clock);
    err_clear = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [10:0] a,
                            input logic [15:0] exp);
    rd_address = a;
    exp_q.push_back(exp);
    @(negedge clock);
    check_output(name, 32'(rd_data), 32'(exp_q.pop_front()));
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, " front_bank"},    32'(front_bank),    32'd0);
    check_output({tag, " frame_pending"}, 32'(frame_pending), 32'd0);
    check_output({tag, " swap_strobe"},   32'(swap_strobe),   32'd0);
    check_output({tag, " seq_error"},     32'(seq_error),     32'd0);
    check_output({tag, " overrun_count"}, 32'(overrun_count), 32'd0);
    check_output({tag, " rd_data"},       32'(rd_data),       32'd0);
  endtask

  initial begin
    t1_vec[0] = '{11'd5,     16'hA5A0};
    t1_vec[1] = '{11'd0,     16'hA5A5};
    t1_vec[2] = '{11'd1,     16'hA5A4};
    t1_vec[3] = '{11'h7FF,   16'hA25A};
    t1_vec[4] = '{11'h400,   16'hA1A5};
    t1_vec[5] = '{11'h123,   16'hA486};
    t1_vec[6] = '{11'h2AA,   16'hA70F};

    reset        = 1'b1;
    wr_data      = '0;
    wr_address   = '0;
    write_strobe = 1'b0;
    scan_vsync   = 1'b0;
    rd_address   = '0;
    err_clear    = 1'b0;
    #1;
    check_reset_values("reset");
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Full frame, then swap.
    write_frame(0, 2046, 16'hA5A5);
    check_output("t1 pending before last", 32'(frame_pending), 32'd0);
    apply_stimulus(11'd2047, 16'(2047) ^ 16'hA5A5, 1'b0, 1'b0);
    check_output("t1 pending after last", 32'(frame_pending), 32'd1);
    check_output("t1 no early swap", 32'(swap_strobe), 32'd0);
    pulse_vsync();
    check_output("t1 front_bank", 32'(front_bank), 32'd1);
    check_output("t1 swap_strobe", 32'(swap_strobe), 32'd1);
    check_output("t1 pending cleared", 32'(frame_pending), 32'd0);
    @(negedge clock);
    check_output("t1 swap single pulse", 32'(swap_strobe), 32'd0);
    for (int i = 0; i < 7; i++) begin
      read_check("t1 read", t1_vec[i].addr, t1_vec[i].exp);
    end
    check_output("t1 seq_error", 32'(seq_error), 32'd0);

    // Out-of-sequence write mid-frame.
    write_frame(0, 9, 16'h1111);
    apply_stimulus(11'd20, 16'h0000, 1'b0, 1'b0);
    check_output("t2 seq_error set", 32'(seq_error), 32'd1);
    check_output("t2 no pending", 32'(frame_pending), 32'd0);
    pulse_clear();
    check_output("t2 seq_error cleared", 32'(seq_error), 32'd0);
    apply_stimulus(11'd7, 16'h0000, 1'b0, 1'b1);
    check_output("t2 set beats clear", 32'(seq_error), 32'd1);
    pulse_clear();
    check_output("t2 cleared again", 32'(seq_error), 32'd0);

    // Resync to address 0 after a partial frame.
    write_frame(0, 99, 16'h3C3C);
    check_output("t3 no error yet", 32'(seq_error), 32'd0);
    apply_stimulus(11'd0, 16'h5A5A, 1'b0, 1'b0);
    check_output("t3 resync error", 32'(seq_error), 32'd1);
    write_frame(1, 2047, 16'h5A5A);
    check_output("t3 pending", 32'(frame_pending), 32'd1);
    pulse_vsync();
    check_output("t3 front_bank", 32'(front_bank), 32'd0);
    read_check("t3 read 50", 11'd50, 16'd50 ^ 16'h5A5A);
    read_check("t3 read 1500", 11'd1500, 16'd1500 ^ 16'h5A5A);
    read_check("t3 read 0", 11'd0, 16'h5A5A);

    // Overrun while pending.
    pulse_clear();
    write_frame(0, 2047, 16'h0F0F);
    check_output("t4 pending", 32'(frame_pending), 32'd1);
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(11'(i), 16'hFFFF, 1'b0, 1'b0);
    end
    check_output("t4 overrun 10", 32'(overrun_count), 32'd10);
    for (int i = 10; i < 300; i++) begin
      apply_stimulus(11'(i), 16'hFFFF, 1'b0, 1'b0);
    end
    check_output("t4 overrun saturated", 32'(overrun_count), 32'd255);
    check_output("t4 front unchanged", 32'(front_bank), 32'd0);
    read_check("t4 old front 50", 11'd50, 16'd50 ^ 16'h5A5A);
    pulse_vsync();
    check_output("t4 front_bank", 32'(front_bank), 32'd1);
    read_check("t4 read 7", 11'd7, 16'd7 ^ 16'h0F0F);
    read_check("t4 read 0", 11'd0, 16'h0F0F);
    pulse_clear();
    check_output("t4 overrun cleared", 32'(overrun_count), 32'd0);

    // Final word and vsync in the same cycle: swap must wait.
    write_frame(0, 2046, 16'h6666);
    apply_stimulus(11'd2047, 16'(2047) ^ 16'h6666, 1'b1, 1'b0);
    check_output("t5 pending", 32'(frame_pending), 32'd1);
    check_output("t5 front held", 32'(front_bank), 32'd1);
    check_output("t5 no swap", 32'(swap_strobe), 32'd0);
    @(negedge clock);
    check_output("t5 still no swap", 32'(swap_strobe), 32'd0);
    pulse_vsync();
    check_output("t5 front swapped", 32'(front_bank), 32'd0);
    check_output("t5 swap_strobe", 32'(swap_strobe), 32'd1);
    read_check("t5 read 2047", 11'h7FF, 16'h6199);

    // Asynchronous reset in the middle of a frame.
    write_frame(0, 2047, 16'h2222);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(11'(i), 16'h0000, 1'b0, 1'b0);
    end
    check_output("t6 overrun 3", 32'(overrun_count), 32'd3);
    pulse_vsync();
    check_output("t6 front 1", 32'(front_bank), 32'd1);
    write_frame(0, 1000, 16'h4444);
    read_check("t6 read 3", 11'd3, 16'h2221);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("t6 async");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    write_frame(0, 2047, 16'h7777);
    check_output("t6 refill pending", 32'(frame_pending), 32'd1);
    check_output("t6 refill no error", 32'(seq_error), 32'd0);
    pulse_vsync();
    check_output("t6 front 1 again", 32'(front_bank), 32'd1);
    read_check("t6 read 1001", 11'd1001, 16'd1001 ^ 16'h7777);
    read_check("t6 read 3 new", 11'd3, 16'd3 ^ 16'h7777);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
